// File: rtl/sigmoid_bwd.sv
// sigmoid_bwd: gradient of the piecewise-linear FP32 sigmoid, g * slope(x), via one shared FP multiplier.
// Optional NaN bypass enabled by defining SIGMOID_BWD_NAN_EN.
`default_nettype none

module sigmoid_bwd #(
    parameter logic [31:0] SLOPE_OUTER = 32'h3D19999A,
    parameter logic [31:0] SLOPE_INNER = 32'h3E428F5C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] g_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] grad_out,
    output logic [2:0]  region,
    output logic        mul_exc,
    output logic        nan_flag
);

    typedef enum logic [1:0] {S_IDLE, S_CLASS, S_MUL, S_DONE} state_e;

    state_e              state_q;
    logic [31:0]         x_q, g_q, slope_q;
    logic                bypass_q, mul_step_q, nan_hit_q;
    logic [47:0]         prod_q;
    logic signed [9:0]   exp_q;
    logic                sign_q, spec_inf_q, spec_zero_q;
    logic                in_ready_q, out_valid_q, mul_exc_q, nan_q;
    logic [31:0]         grad_q;
    logic [2:0]          region_q;

    logic [2:0]          region_d;
    logic [31:0]         slope_d;
    logic                nan_d;
    logic [31:0]         mul_res_d;
    logic                mul_flag_d;

    // Strict less-than against -5, -2, 2, 5 on sign/magnitude bits; -0 lands in the centre.
    always_comb begin
        logic lt_m5, lt_m2, lt_p2, lt_p5;
        lt_m5 = x_q[31] & (x_q[30:0] > 31'h40A00000);
        lt_m2 = x_q[31] & (x_q[30:0] > 31'h40000000);
        lt_p2 = x_q[31] | (x_q[30:0] < 31'h40000000);
        lt_p5 = x_q[31] | (x_q[30:0] < 31'h40A00000);
        region_d = 3'd4;
        slope_d  = 32'h0;
        if (lt_m5) begin
            region_d = 3'd0;
        end else if (lt_m2) begin
            region_d = 3'd1;
            slope_d  = SLOPE_OUTER;
        end else if (lt_p2) begin
            region_d = 3'd2;
            slope_d  = SLOPE_INNER;
        end else if (lt_p5) begin
            region_d = 3'd3;
            slope_d  = SLOPE_OUTER;
        end
    end

`ifdef SIGMOID_BWD_NAN_EN
    assign nan_d = ((x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'h0)) ||
                   ((g_q[30:23] == 8'hFF) && (g_q[22:0] != 23'h0));
`else
    assign nan_d = 1'b0;
`endif

    // Second multiplier stage: normalise, round to nearest-even, flag overflow/underflow.
    always_comb begin
        logic              norm, guard, sticky, rnd;
        logic [22:0]       mant;
        logic [23:0]       mant_r;
        logic signed [9:0] exp_f;
        norm   = prod_q[47];
        if (norm) begin
            mant   = prod_q[46:24];
            guard  = prod_q[23];
            sticky = |prod_q[22:0];
        end else begin
            mant   = prod_q[45:23];
            guard  = prod_q[22];
            sticky = |prod_q[21:0];
        end
        rnd        = guard & (sticky | mant[0]);
        mant_r     = {1'b0, mant} + {23'h0, rnd};
        exp_f      = exp_q + $signed({9'h0, norm}) + $signed({9'h0, mant_r[23]});
        mul_res_d  = {sign_q, exp_f[7:0], mant_r[22:0]};
        mul_flag_d = 1'b0;
        if (spec_inf_q) begin
            mul_res_d  = {sign_q, 8'hFF, 23'h0};
            mul_flag_d = 1'b1;
        end else if (spec_zero_q) begin
            mul_res_d  = {sign_q, 31'h0};
        end else if (exp_f > 10'sd254) begin
            mul_res_d  = {sign_q, 8'hFF, 23'h0};
            mul_flag_d = 1'b1;
        end else if (exp_f < 10'sd1) begin
            mul_res_d  = {sign_q, 31'h0};
            mul_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= 32'h0;
            g_q         <= 32'h0;
            slope_q     <= 32'h0;
            bypass_q    <= 1'b0;
            mul_step_q  <= 1'b0;
            nan_hit_q   <= 1'b0;
            prod_q      <= 48'h0;
            exp_q       <= 10'sd0;
            sign_q      <= 1'b0;
            spec_inf_q  <= 1'b0;
            spec_zero_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            grad_q      <= 32'h0;
            region_q    <= 3'd0;
            mul_exc_q   <= 1'b0;
            nan_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q        <= x_in;
                        g_q        <= g_in;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CLASS;
                    end
                end
                S_CLASS: begin
                    region_q   <= region_d;
                    slope_q    <= slope_d;
                    bypass_q   <= (slope_d == 32'h0);
                    nan_hit_q  <= nan_d;
                    mul_step_q <= 1'b0;
                    state_q    <= S_MUL;
                end
                S_MUL: begin
                    if (nan_hit_q) begin
                        grad_q      <= 32'h7FC00000;
                        region_q    <= 3'd0;
                        mul_exc_q   <= 1'b0;
                        nan_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (!mul_step_q) begin
                        prod_q      <= {24'h0, 1'b1, g_q[22:0]} * {24'h0, 1'b1, slope_q[22:0]};
                        exp_q       <= $signed({2'b00, g_q[30:23]}) + $signed({2'b00, slope_q[30:23]}) - 10'sd127;
                        sign_q      <= g_q[31] ^ slope_q[31];
                        spec_inf_q  <= (g_q[30:23] == 8'hFF) || (slope_q[30:23] == 8'hFF);
                        spec_zero_q <= (g_q[30:23] == 8'h00) || (slope_q[30:23] == 8'h00);
                        mul_step_q  <= 1'b1;
                    end else begin
                        grad_q      <= bypass_q ? 32'h0 : mul_res_d;
                        mul_exc_q   <= bypass_q ? 1'b0 : mul_flag_d;
                        nan_q       <= 1'b0;
                        mul_step_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign grad_out  = grad_q;
    assign region    = region_q;
    assign mul_exc   = mul_exc_q;

`ifdef SIGMOID_BWD_NAN_EN
    assign nan_flag = nan_q;
`else
    assign nan_flag = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_bwd.sv
// tb_sigmoid_bwd: directed scoreboard bench for sigmoid_bwd.
`default_nettype none

module tb_sigmoid_bwd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x_in = 32'h0;
    logic [31:0] g_in = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] grad_out;
    logic [2:0]  region;
    logic        mul_exc;
    logic        nan_flag;

    sigmoid_bwd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .g_in      (g_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grad_out  (grad_out),
        .region    (region),
        .mul_exc   (mul_exc),
        .nan_flag  (nan_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] grad;
        logic [2:0]  reg_idx;
        logic        exc;
        logic        nan;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one transaction, wait (bounded) for out_valid, then score it.
    task automatic run_txn(input string tag, input logic [31:0] x, input logic [31:0] g,
                           input logic [31:0] eg, input logic [2:0] er, input logic ee,
                           input logic en, input int lat, input logic chk_grad);
        exp_t e;
        int   cyc;
        sb.push_back('{grad: eg, reg_idx: er, exc: ee, nan: en, lat: lat});
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
        x_in = x; g_in = g; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h0, 32'h1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
            if (chk_grad) chk({tag, "_grad"}, grad_out, e.grad);
            chk({tag, "_region"}, {29'h0, region}, {29'h0, e.reg_idx});
            chk({tag, "_exc"}, {31'h0, mul_exc}, {31'h0, e.exc});
            chk({tag, "_nan"}, {31'h0, nan_flag}, {31'h0, e.nan});
        end
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_ready_after"}, {31'h0, in_ready}, 32'h1);
            chk({tag, "_valid_drop"}, {31'h0, out_valid}, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_grad;
        logic [2:0]  held_reg;
        int          seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_grad", grad_out, 32'h0);
        chk("rst_region", {29'h0, region}, 32'h0);
        chk("rst_exc", {31'h0, mul_exc}, 32'h0);
        chk("rst_nan", {31'h0, nan_flag}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("zero",    32'h00000000, 32'h3F800000, 32'h3E428F5C, 3'd2, 1'b0, 1'b0, 3, 1'b1);
        run_txn("neg3",    32'hC0400000, 32'h40000000, 32'h3D99999A, 3'd1, 1'b0, 1'b0, 3, 1'b1);
        run_txn("bnd_m5",  32'hC0A00000, 32'h3F800000, 32'h3D19999A, 3'd1, 1'b0, 1'b0, 3, 1'b1);
        run_txn("bnd_p5",  32'h40A00000, 32'h3F800000, 32'h00000000, 3'd4, 1'b0, 1'b0, 3, 1'b1);
        run_txn("bnd_m2",  32'hC0000000, 32'h3F800000, 32'h3E428F5C, 3'd2, 1'b0, 1'b0, 3, 1'b1);
        run_txn("pos3",    32'h40400000, 32'hC0800000, 32'hBE19999A, 3'd3, 1'b0, 1'b0, 3, 1'b1);
        run_txn("neg10",   32'hC1200000, 32'h40000000, 32'h00000000, 3'd0, 1'b0, 1'b0, 3, 1'b1);
        run_txn("bnd_p2",  32'h40000000, 32'h3F800000, 32'h3D19999A, 3'd3, 1'b0, 1'b0, 3, 1'b1);
        run_txn("uflow",   32'h00000000, 32'h00800000, 32'h00000000, 3'd2, 1'b1, 1'b0, 3, 1'b0);

        // Backpressure: result must hold and in_valid pulses must be ignored.
        out_ready = 1'b0;
        run_txn("bp",      32'hC0400000, 32'h40000000, 32'h3D99999A, 3'd1, 1'b0, 1'b0, 3, 1'b1);
        held_grad = 32'h3D99999A;
        held_reg  = 3'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x_in = 32'h40C00000;
            g_in = 32'h3F800000;
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_hold_grad", grad_out, held_grad);
            chk("bp_hold_region", {29'h0, region}, {29'h0, held_reg});
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", {31'h0, in_ready}, 32'h1);
        chk("bp_release_valid", {31'h0, out_valid}, 32'h0);
        chk("bp_keep_grad", grad_out, held_grad);

        run_txn("negzero", 32'h80000000, 32'h3F800000, 32'h3E428F5C, 3'd2, 1'b0, 1'b0, 3, 1'b1);

        // Reset while in MUL: abort with no result after release.
        @(negedge clk);
        x_in = 32'hC0400000; g_in = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("mid_rst_no_stale", 32'(seen), 32'h0);
        run_txn("post_rst", 32'hC0A00000, 32'h40000000, 32'h3D99999A, 3'd1, 1'b0, 1'b0, 3, 1'b1);

`ifdef SIGMOID_BWD_NAN_EN
        run_txn("nan_x",   32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'd0, 1'b0, 1'b1, 2, 1'b1);
`else
        run_txn("nan_x",   32'h7FC00000, 32'h3F800000, 32'h00000000, 3'd4, 1'b0, 1'b0, 3, 1'b1);
`endif
        run_txn("after_nan", 32'h00000000, 32'h3F800000, 32'h3E428F5C, 3'd2, 1'b0, 1'b0, 3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
